// File: rtl/nts_engine_tx_buffer.sv
// Engine-side TX packet buffer: holds one committed packet and streams it to the extractor.
// The extractor releases the buffer with packet_read.
module nts_engine_tx_buffer #(
    parameter int unsigned ADDR_WIDTH            = 8,
    parameter int unsigned MAC_DATA_WIDTH        = 64,
    parameter int unsigned LAST_DATA_VALID_WIDTH = 4
) (
    input  logic                             i_clk,
    input  logic                             i_areset_n,
    input  logic                             i_clear,
    output logic                             o_write_ready,
    input  logic                             i_write_en,
    input  logic [MAC_DATA_WIDTH-1:0]        i_write_data,
    input  logic                             i_commit,
    input  logic [LAST_DATA_VALID_WIDTH-1:0] i_commit_bytes_last_word,
    output logic                             o_write_overflow,
    output logic                             o_packet_available,
    input  logic                             i_packet_read,
    output logic                             o_fifo_empty,
    input  logic                             i_fifo_rd_start,
    output logic                             o_fifo_rd_valid,
    output logic [MAC_DATA_WIDTH-1:0]        o_fifo_rd_data,
    output logic [LAST_DATA_VALID_WIDTH-1:0] o_bytes_last_word
);

    localparam logic [LAST_DATA_VALID_WIDTH-1:0] BYTES_PER_WORD =
        LAST_DATA_VALID_WIDTH'(MAC_DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {StWrite, StAvailable, StRead, StDone} state_e;

    state_e                           state_q;
    logic [ADDR_WIDTH:0]              word_count_q;
    logic [ADDR_WIDTH:0]              rd_ptr_q;
    logic                             overflow_q;
    logic                             fifo_empty_q;
    logic                             rd_valid_q;
    logic                             read_pending_q;
    logic [LAST_DATA_VALID_WIDTH-1:0] bytes_last_word_q;
    logic [MAC_DATA_WIDTH-1:0]        ram_q;
    logic [MAC_DATA_WIDTH-1:0]        mem [2**ADDR_WIDTH];

    logic                full;
    logic                wr_accept;
    logic                wr_drop;
    logic                overflow_next;
    logic [ADDR_WIDTH:0] count_next;
    logic                bytes_ok;
    logic                commit_ok;
    logic                rd_issue;
    logic                rd_last_issue;
    logic                release_pkt;

    always_comb begin
        full          = word_count_q[ADDR_WIDTH];
        wr_accept     = (state_q == StWrite) && i_write_en && !full;
        wr_drop       = (state_q == StWrite) && i_write_en && full;
        overflow_next = overflow_q | wr_drop;
        // A write in the commit cycle belongs to the committed packet.
        count_next    = word_count_q + {{ADDR_WIDTH{1'b0}}, wr_accept};
        bytes_ok      = (i_commit_bytes_last_word != '0) &&
                        (i_commit_bytes_last_word <= BYTES_PER_WORD);
        commit_ok     = bytes_ok && (count_next != '0) && !overflow_next;
        rd_issue      = (state_q == StRead) && (rd_ptr_q < word_count_q);
        rd_last_issue = rd_issue && ((rd_ptr_q + PTR_ONE) == word_count_q);
        release_pkt   = ((state_q == StAvailable) && i_packet_read) ||
                        ((state_q == StDone) && (i_packet_read || read_pending_q));
    end

    always_ff @(posedge i_clk) begin
        if (wr_accept) begin
            mem[word_count_q[ADDR_WIDTH-1:0]] <= i_write_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (rd_issue) begin
            ram_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
        end
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_q           <= StWrite;
            word_count_q      <= '0;
            rd_ptr_q          <= '0;
            overflow_q        <= 1'b0;
            fifo_empty_q      <= 1'b1;
            rd_valid_q        <= 1'b0;
            read_pending_q    <= 1'b0;
            bytes_last_word_q <= '0;
        end else if (i_clear || release_pkt) begin
            state_q           <= StWrite;
            word_count_q      <= '0;
            rd_ptr_q          <= '0;
            overflow_q        <= 1'b0;
            fifo_empty_q      <= 1'b1;
            rd_valid_q        <= 1'b0;
            read_pending_q    <= 1'b0;
            bytes_last_word_q <= '0;
        end else begin
            rd_valid_q <= rd_issue;
            unique case (state_q)
                StWrite: begin
                    word_count_q <= count_next;
                    overflow_q   <= overflow_next;
                    if (i_commit) begin
                        if (commit_ok) begin
                            state_q           <= StAvailable;
                            bytes_last_word_q <= i_commit_bytes_last_word;
                            fifo_empty_q      <= 1'b0;
                        end else begin
                            word_count_q <= '0;
                            overflow_q   <= 1'b0;
                        end
                    end
                end
                StAvailable: begin
                    if (i_fifo_rd_start) begin
                        rd_ptr_q <= '0;
                        state_q  <= StRead;
                    end
                end
                StRead: begin
                    if (i_packet_read) begin
                        read_pending_q <= 1'b1;
                    end
                    if (rd_issue) begin
                        rd_ptr_q <= rd_ptr_q + PTR_ONE;
                        if (rd_last_issue) begin
                            fifo_empty_q <= 1'b1;
                        end
                    end else begin
                        // Last word is on the output this cycle.
                        state_q <= StDone;
                    end
                end
                StDone: begin
                end
                default: state_q <= StWrite;
            endcase
        end
    end

    assign o_write_ready      = (state_q == StWrite);
    assign o_packet_available = (state_q != StWrite);
    assign o_write_overflow   = overflow_q;
    assign o_fifo_empty       = fifo_empty_q;
    assign o_fifo_rd_valid    = rd_valid_q;
    assign o_fifo_rd_data     = rd_valid_q ? ram_q : '0;
    assign o_bytes_last_word  = bytes_last_word_q;

endmodule

// File: doc/nts_engine_tx_buffer.md
Name: nts_engine_tx_buffer

Overview:
- Engine-side transmit packet buffer: the far end of the extractor's per-engine TX FIFO interface (packet_available / packet_read / fifo_empty / rd_start / rd_valid / rd_data / bytes_last_word).
- The engine's response builder writes one complete packet into an internal RAM and commits it.
- The buffer then advertises the packet, streams it word-by-word to the extractor on request, and frees itself when the extractor signals packet_read.
- Single packet in flight; one instance per engine.

Parameters:
ADDR_WIDTH, 8, RAM address width; depth = 2**ADDR_WIDTH words.
MAC_DATA_WIDTH, 64, word width in bits (8 bytes per word).
LAST_DATA_VALID_WIDTH, 4, width of the last-word byte-count field.

Ports:
i_clk  in  1  clock
i_areset_n  in  1  asynchronous active-low reset
i_clear  in  1  synchronous abort; returns the block to WRITE from any state
o_write_ready  in->out  1  high in WRITE state
i_write_en  in  1  write i_write_data at the write pointer
i_write_data  in  MAC_DATA_WIDTH  packet word, byte 0 in MSBs
i_commit  in  1  end of packet
i_commit_bytes_last_word  in  LAST_DATA_VALID_WIDTH  valid bytes in the final word, 1..8
o_write_overflow  out  1  sticky; word dropped because buffer was full
o_packet_available  out  1  committed packet awaiting the extractor
i_packet_read  in  1  extractor done; release the buffer
o_fifo_empty  out  1  no further words to issue
i_fifo_rd_start  in  1  begin streaming the committed packet
o_fifo_rd_valid  out  1  o_fifo_rd_data valid this cycle
o_fifo_rd_data  out  MAC_DATA_WIDTH  packet word
o_bytes_last_word  out  LAST_DATA_VALID_WIDTH  committed last-word byte count

Behaviour:
- Reset (i_areset_n=0, async):
  - State goes to WRITE.
  - wr_ptr, word_count and rd_ptr are cleared to 0.
  - Outputs: o_write_ready=1, o_write_overflow=0, o_packet_available=0, o_fifo_empty=1, o_fifo_rd_valid=0, o_fifo_rd_data=0, o_bytes_last_word=0.
  - RAM contents are not reset.
- Counters: word_count and rd_ptr are ADDR_WIDTH+1 bits so a full buffer (2**ADDR_WIDTH) is representable. No wrap-around.
- States: WRITE, AVAILABLE, READ, DONE.
- WRITE:
  - i_write_en with word_count < depth: RAM[wr_ptr] <= data, word_count increments.
  - i_write_en at word_count == depth: the word is dropped and o_write_overflow is set.
  - i_commit with word_count > 0 and no overflow: latch bytes_last_word, go to AVAILABLE. o_packet_available=1 and o_fifo_empty=0 from the next cycle.
  - i_commit with word_count == 0 or overflow set: discard the packet, clear the counters and overflow, stay in WRITE.
  - i_write_en and i_commit in the same cycle: the word is written first and is included in the committed packet.
  - i_commit_bytes_last_word of 0 or >8: discard as above.
- Writes and commits outside WRITE are ignored.
- AVAILABLE:
  - i_fifo_rd_start: rd_ptr <= 0, go to READ.
  - i_packet_read without a prior read: discard the packet and go to WRITE.
  - i_fifo_rd_start outside AVAILABLE is ignored.
- READ:
  - Each cycle with rd_ptr < word_count, issue a RAM read at rd_ptr and increment rd_ptr.
  - Synchronous RAM latency is 1: o_fifo_rd_valid/o_fifo_rd_data appear one cycle after issue, back-to-back with no gaps.
  - First valid word appears 2 cycles after the rd_start cycle.
  - o_fifo_empty asserts in the cycle after the last word is issued, i.e. coincident with the last o_fifo_rd_valid.
  - After the last valid word, go to DONE.
  - o_fifo_rd_data returns to 0 whenever rd_valid=0.
- DONE:
  - o_packet_available stays 1 and o_fifo_empty=1.
  - i_packet_read: clear pointers, o_packet_available=0 next cycle, go to WRITE.
  - i_fifo_rd_start in DONE is ignored; no re-read.
- i_packet_read during READ is latched and takes effect on entry to DONE; the stream is never truncated.
- i_clear has priority over every other input in every state. An in-flight rd_valid pipeline stage is suppressed.
- o_bytes_last_word holds its value from commit until release, then returns to 0.

Test Plan:
- Reset mid-READ of a 10-word packet -> all outputs at reset values immediately; a new 1-word packet then streams correctly.
- Write 3 words A, B, C; commit with bytes=5 -> o_packet_available=1, o_bytes_last_word=5. rd_start at cycle t -> rd_valid at t+2..t+4 with A, B, C; o_fifo_empty=1 at t+4. packet_read -> available=0, o_write_ready=1.
- Depth 256, 257 writes, then commit -> overflow=1, packet discarded, available stays 0; overflow cleared after commit.
- Commit with zero words, and commit with bytes=0 -> no packet_available, state remains WRITE.
- write_en with commit in the same cycle on the 4th word -> 4 words streamed. packet_read asserted during READ -> all 4 delivered, then release.
- i_clear in AVAILABLE and in READ at the 2nd word -> rd_valid drops next cycle, available=0, write_ready=1. Writes in AVAILABLE ignored (streamed data unchanged).
